// File: rtl/sevenseg_if.sv
// sevenseg_if: display value/control inputs and anode/segment outputs of the scan controller
interface sevenseg_if #(
  parameter int NUM_DIGITS = 8,
  parameter int PWM_BITS   = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    blank_lz;
  logic [PWM_BITS-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp_out;
  logic                    frame_start;
  modport master (
    output value, dp, digit_en, blank_lz, brightness,
    input  an, seg, dp_out, frame_start
  );
  modport slave (
    input  value, dp, digit_en, blank_lz, brightness,
    output an, seg, dp_out, frame_start
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed hex display scanner with frame snapshot, blanking and PWM dimming
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 100000,
  parameter int PWM_BITS   = 4,
  parameter bit ACTIVE_LOW = 1
) (
  input logic       clk,
  input logic       Rst,
  sevenseg_if.slave bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  logic [PW-1:0]           pre_cnt;
  logic [IW-1:0]           idx;
  logic [PWM_BITS-1:0]     pwm_cnt;
  logic                    snap_pend;
  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic                    sh_blank;
  logic                    tick;
  logic                    wrap;
  logic                    pwm_on;
  logic                    lit;
  logic                    zero_run;
  logic [IW-1:0]           sel;
  logic [3:0]              nib;
  logic [6:0]              dec;
  logic [NUM_DIGITS-1:0]   dark;
  assign tick   = pre_cnt == PRE_MAX;
  assign wrap   = tick && idx == LAST;
  assign sel    = idx <= LAST ? idx : '0;
  assign nib    = sh_value[4*sel +: 4];
  assign pwm_on = &bus.brightness || pwm_cnt < bus.brightness;
  assign lit    = pwm_on && !dark[sel];
  // walk from the most significant digit down, tracking whether everything above is zero
  always_comb begin
    zero_run = 1'b1;
    dark = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && sh_value[4*i +: 4] == 4'd0;
      dark[i] = !sh_en[i] || (sh_blank && i > 0 && zero_run);
    end
  end
  // hex to active-low abcdefg segment code
  always_comb begin
    case (nib)
      4'h0: dec = 7'b0000001;
      4'h1: dec = 7'b1001111;
      4'h2: dec = 7'b0010010;
      4'h3: dec = 7'b0000110;
      4'h4: dec = 7'b1001100;
      4'h5: dec = 7'b0100100;
      4'h6: dec = 7'b0100000;
      4'h7: dec = 7'b0001111;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0000100;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b1100000;
      4'hC: dec = 7'b0110001;
      4'hD: dec = 7'b1000010;
      4'hE: dec = 7'b0110000;
      default: dec = 7'b0111000;
    endcase
  end
  // prescaler, digit scan, frame snapshot and registered pin drive
  always_ff @(posedge clk) begin
    if (Rst) begin
      pre_cnt         <= '0;
      idx             <= '0;
      pwm_cnt         <= '0;
      snap_pend       <= 1'b1;
      sh_value        <= '0;
      sh_dp           <= '0;
      sh_en           <= '0;
      sh_blank        <= 1'b0;
      bus.an          <= {NUM_DIGITS{ACTIVE_LOW}};
      bus.seg         <= {7{ACTIVE_LOW}};
      bus.dp_out      <= ACTIVE_LOW;
      bus.frame_start <= 1'b0;
    end else begin
      pre_cnt         <= tick ? '0 : pre_cnt + 1'b1;
      idx             <= tick ? (wrap ? '0 : idx + 1'b1) : idx;
      pwm_cnt         <= pwm_cnt + 1'b1;
      snap_pend       <= wrap;
      bus.frame_start <= snap_pend;
      if (snap_pend) begin
        sh_value <= bus.value;
        sh_dp    <= bus.dp;
        sh_en    <= bus.digit_en;
        sh_blank <= bus.blank_lz;
      end
      bus.an     <= (lit ? NUM_DIGITS'(1) << sel : '0) ^ {NUM_DIGITS{ACTIVE_LOW}};
      bus.seg    <= lit ? (ACTIVE_LOW ? dec : ~dec) : {7{ACTIVE_LOW}};
      bus.dp_out <= (lit && sh_dp[sel]) ^ ACTIVE_LOW;
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: directed checks of scan, snapshot, blanking, PWM and reset behaviour
module tb_sevenseg_scan_ctrl;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int passed = 0;
  int total = 0;
  int cyc = 0;
  int n;
  logic [6:0] code [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  always #5 clk = ~clk;
  sevenseg_if #(.NUM_DIGITS(8), .PWM_BITS(4)) ia ();
  sevenseg_if #(.NUM_DIGITS(1), .PWM_BITS(4)) ib ();
  sevenseg_scan_ctrl #(.NUM_DIGITS(8), .DIV(4), .PWM_BITS(4), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .Rst(rst_a), .bus(ia));
  sevenseg_scan_ctrl #(.NUM_DIGITS(1), .DIV(1), .PWM_BITS(4), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .Rst(rst_b), .bus(ib));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic upto(input int c);
    while (cyc < c) step();
  endtask
  function automatic logic [7:0] an_on(input int k);
    return ~(8'd1 << k);
  endfunction
  initial begin
    ia.value = 32'h1234_5678;
    ia.dp = 8'h04;
    ia.digit_en = 8'hFF;
    ia.blank_lz = 1'b0;
    ia.brightness = 4'hF;
    ib.value = 4'h8;
    ib.dp = 1'b1;
    ib.digit_en = 1'b1;
    ib.blank_lz = 1'b0;
    ib.brightness = 4'hF;
    step();
    step();
    chk("rst_an", ia.an, 8'hFF);
    chk("rst_seg", ia.seg, 7'h7F);
    chk("rst_dp", ia.dp_out, 1'b1);
    chk("rst_fs", ia.frame_start, 1'b0);
    chk("rst_b_an", ib.an, 1'b0);
    chk("rst_b_seg", ib.seg, 7'h00);
    chk("rst_b_dp", ib.dp_out, 1'b0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    cyc = 0;
    step();
    chk("fs_first", ia.frame_start, 1'b1);
    chk("an_first", ia.an, 8'hFF);
    chk("b_an_first", ib.an, 1'b0);
    step();
    chk("fs_drop", ia.frame_start, 1'b0);
    chk("b_an", ib.an, 1'b1);
    chk("b_seg8", ib.seg, 7'h7F);
    chk("b_dp", ib.dp_out, 1'b1);
    for (int k = 0; k < 8; k++) begin
      upto(4 * k + 2);
      chk($sformatf("scan_an%0d", k), ia.an, an_on(k));
      chk($sformatf("scan_seg%0d", k), ia.seg, code[8 - k]);
      chk($sformatf("scan_dp%0d", k), ia.dp_out, k == 2 ? 1'b0 : 1'b1);
    end
    upto(32);
    chk("fs_e32", ia.frame_start, 1'b0);
    upto(33);
    chk("fs_e33", ia.frame_start, 1'b1);
    upto(34);
    chk("fs_e34", ia.frame_start, 1'b0);
    upto(46);
    ia.value = 32'hFFFF_FFFF;
    for (int k = 3; k < 8; k++) begin
      upto(32 + 4 * k + 2);
      chk($sformatf("hold_an%0d", k), ia.an, an_on(k));
      chk($sformatf("hold_seg%0d", k), ia.seg, code[8 - k]);
    end
    upto(65);
    chk("fs_e65", ia.frame_start, 1'b1);
    upto(66);
    chk("new_an0", ia.an, 8'hFE);
    chk("new_seg0", ia.seg, code[15]);
    upto(70);
    chk("new_seg1", ia.seg, code[15]);
    ia.value = 32'h0000_00A0;
    ia.blank_lz = 1'b1;
    upto(98);
    chk("lz_an0", ia.an, 8'hFE);
    chk("lz_seg0", ia.seg, code[0]);
    upto(102);
    chk("lz_an1", ia.an, 8'hFD);
    chk("lz_seg1", ia.seg, code[10]);
    for (int k = 2; k < 8; k++) begin
      upto(96 + 4 * k + 2);
      chk($sformatf("lz_dark_an%0d", k), ia.an, 8'hFF);
      chk($sformatf("lz_dark_seg%0d", k), ia.seg, 7'h7F);
    end
    ia.value = 32'h0;
    upto(130);
    chk("zero_an0", ia.an, 8'hFE);
    chk("zero_seg0", ia.seg, code[0]);
    upto(134);
    chk("zero_an1", ia.an, 8'hFF);
    ia.value = 32'h1234_5678;
    ia.blank_lz = 1'b0;
    upto(162);
    ia.brightness = 4'h4;
    n = 0;
    repeat (16) begin
      step();
      if (ia.an !== 8'hFF) n++;
    end
    chk("pwm_4", n, 4);
    ia.brightness = 4'h0;
    n = 0;
    repeat (16) begin
      step();
      if (ia.an !== 8'hFF) n++;
    end
    chk("pwm_0", n, 0);
    ia.brightness = 4'hF;
    n = 0;
    repeat (16) begin
      step();
      if (ia.an !== 8'hFF) n++;
    end
    chk("pwm_f", n, 16);
    upto(245);
    chk("pre_rst_an5", ia.an, an_on(5));
    chk("pre_rst_seg5", ia.seg, code[3]);
    rst_a = 1'b1;
    step();
    chk("mid_rst_an", ia.an, 8'hFF);
    chk("mid_rst_seg", ia.seg, 7'h7F);
    chk("mid_rst_fs", ia.frame_start, 1'b0);
    step();
    rst_a = 1'b0;
    cyc = 0;
    step();
    chk("rel_fs", ia.frame_start, 1'b1);
    chk("rel_an", ia.an, 8'hFF);
    step();
    chk("rel_fs_drop", ia.frame_start, 1'b0);
    chk("rel_an0", ia.an, 8'hFE);
    chk("rel_seg0", ia.seg, code[8]);
    upto(6);
    chk("rel_an1", ia.an, 8'hFD);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
